// File: rtl/bcd_serial_adder_pkg.sv
// bcd_serial_adder_pkg: shared FSM encoding, BCD constants and counter-width helper
package bcd_serial_adder_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;
  function automatic int clog2(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/bcd_digit_adder.sv
// bcd_digit_adder: one-digit BCD add with decimal correction above nine
module bcd_digit_adder
  import bcd_serial_adder_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] t;
  assign t = {1'b0, x} + {1'b0, y} + {4'b0, cin};
  assign cout = t > {1'b0, BCD_MAX};
  assign s = cout ? t[3:0] + BCD_CORR : t[3:0];
endmodule

// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: digit-serial N-digit BCD adder/subtractor, LSD first
module bcd_serial_adder
  import bcd_serial_adder_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                sub,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err
);
  localparam int W = 4 * DIGITS;
  localparam int CW = clog2(DIGITS);
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);
  state_t state, state_n;
  logic [W-1:0] a_sr, b_sr, res, res_n;
  logic [CW-1:0] cnt;
  logic [3:0] bd, dig;
  logic sub_r, c_r, err_p, accept, last, bad, dco;
  assign busy = state == S_RUN;
  assign done = state == S_DONE;
  assign accept = start && !busy;
  assign last = cnt == LAST;
  assign bd = sub_r ? BCD_MAX - b_sr[3:0] : b_sr[3:0];
  assign res_n = W'({dig, res} >> 4);
  bcd_digit_adder u_digit (
    .x   (a_sr[3:0]),
    .y   (bd),
    .cin (c_r),
    .s   (dig),
    .cout(dco)
  );
  // flag any operand digit above nine at accept time
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) bad = bad | (a[4*i+:4] > BCD_MAX) | (b[4*i+:4] > BCD_MAX);
  end
  // next state: RUN until the last digit, otherwise start decides
  always_comb begin
    state_n = busy ? (last ? S_DONE : S_RUN) : (start ? S_RUN : S_IDLE);
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else state <= state_n;
  end
  // operand shifting, digit accumulation and result capture on the last digit
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr <= '0;
      b_sr <= '0;
      res <= '0;
      cnt <= '0;
      sub_r <= 1'b0;
      c_r <= 1'b0;
      err_p <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
      err <= 1'b0;
    end else if (accept) begin
      a_sr <= a;
      b_sr <= b;
      res <= '0;
      cnt <= '0;
      sub_r <= sub;
      c_r <= sub;
      err_p <= bad;
    end else if (busy) begin
      a_sr <= a_sr >> 4;
      b_sr <= b_sr >> 4;
      res <= res_n;
      cnt <= cnt + 1'b1;
      c_r <= dco;
      if (last) begin
        sum <= err_p ? '0 : res_n;
        cout <= !err_p && dco;
        err <= err_p;
      end
    end
  end
endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb_bcd_serial_adder: directed checks of the serial BCD adder at 4 and 1 digits
module tb_bcd_serial_adder;
  logic clk, rst;
  logic start, sub, busy, done, cout, err;
  logic [15:0] a, b, sum;
  logic start1, sub1, busy1, done1, cout1, err1;
  logic [3:0] a1, b1, sum1;
  int tests = 0;
  int fails = 0;

  bcd_serial_adder #(.DIGITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
  );

  bcd_serial_adder #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .err(err1)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic op(input string tag, input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                    input logic [15:0] es, input logic ec, input logic ee);
    start = 1;
    a = ta;
    b = tb_;
    sub = ts;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 0;
      chk({tag, " busy"}, busy, 1);
      chk({tag, " early done"}, done, 0);
    end
    @(negedge clk);
    chk({tag, " done"}, done, 1);
    chk({tag, " busy at done"}, busy, 0);
    chk({tag, " sum"}, sum, es);
    chk({tag, " cout"}, cout, ec);
    chk({tag, " err"}, err, ee);
  endtask

  initial begin
    rst = 1;
    start = 0; sub = 0; a = 0; b = 0;
    start1 = 0; sub1 = 0; a1 = 0; b1 = 0;
    repeat (2) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst sum", sum, 0);
    chk("rst cout", cout, 0);
    chk("rst err", err, 0);
    rst = 0;
    @(negedge clk);
    op("add66", 16'h0066, 16'h0066, 0, 16'h0132, 0, 0);
    @(negedge clk);
    op("add9999", 16'h9999, 16'h0001, 0, 16'h0000, 1, 0);
    @(negedge clk);
    op("add0999", 16'h0999, 16'h0001, 0, 16'h1000, 0, 0);
    @(negedge clk);
    op("add4567", 16'h4567, 16'h5678, 0, 16'h0245, 1, 0);
    @(negedge clk);
    op("sub5m3", 16'h0005, 16'h0003, 1, 16'h0002, 1, 0);
    @(negedge clk);
    op("sub3m5", 16'h0003, 16'h0005, 1, 16'h9998, 0, 0);
    @(negedge clk);
    op("subeq", 16'h1234, 16'h1234, 1, 16'h0000, 1, 0);
    @(negedge clk);
    op("errA1", 16'h00A1, 16'h0001, 0, 16'h0000, 0, 1);
    @(negedge clk);
    op("errclr", 16'h1234, 16'h4321, 0, 16'h5555, 0, 0);
    // start during RUN must be ignored
    @(negedge clk);
    start = 1; a = 16'h1111; b = 16'h2222; sub = 0;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    start = 1; a = 16'h9999; b = 16'h9999; sub = 1;
    @(negedge clk);
    start = 0;
    chk("ign busy3", busy, 1);
    @(negedge clk);
    @(negedge clk);
    chk("ign done", done, 1);
    chk("ign sum", sum, 16'h3333);
    chk("ign cout", cout, 0);
    // reset mid-run aborts without a done pulse
    @(negedge clk);
    start = 1; a = 16'h1111; b = 16'h2222; sub = 0;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort busy", busy, 0);
    chk("abort sum", sum, 0);
    chk("abort done", done, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort no done", done, 0);
    end
    // back-to-back: start held in DONE re-enters RUN directly
    op("b2b first", 16'h0066, 16'h0066, 0, 16'h0132, 0, 0);
    op("b2b second", 16'h1234, 16'h4321, 0, 16'h5555, 0, 0);
    @(negedge clk);
    chk("b2b idle", busy, 0);
    // single-digit instance
    start1 = 1; a1 = 4'h6; b1 = 4'h6; sub1 = 0;
    @(negedge clk);
    start1 = 0;
    chk("d1 busy", busy1, 1);
    chk("d1 early done", done1, 0);
    @(negedge clk);
    chk("d1 done", done1, 1);
    chk("d1 busy at done", busy1, 0);
    chk("d1 sum", sum1, 4'h2);
    chk("d1 cout", cout1, 1);
    chk("d1 err", err1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
